// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Port index width; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wait counter width, wide enough to hold WAIT_CYCLES itself.
    function automatic int wait_w(input int w);
        return (w > 0) ? $clog2(w + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: fixed priority by default, or round-robin
// from ptr+1 when MEM_ARB_RR_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 hit
);

`ifdef MEM_ARB_RR_EN
    // Walk offsets from farthest to nearest so the nearest valid port after ptr wins.
    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            c = (int'(ptr) + i) % NUM_PORTS;
            if (valid[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
                hit    = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (valid[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                hit    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter with programmable wait states.
// Define MEM_ARB_RR_EN for round-robin priority instead of fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 3,
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_PORTS-1:0]    req_valid,
    input  logic [NUM_PORTS-1:0]    req_we,
    input  logic [NUM_PORTS*AW-1:0] req_addr,
    input  logic [NUM_PORTS*DW-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]    req_ready,
    output logic [NUM_PORTS-1:0]    rsp_valid,
    output logic [DW-1:0]           rsp_rdata,
    output logic [AW-1:0]           mem_addr,
    output logic                    mem_we,
    output logic [DW-1:0]           mem_wd,
    input  logic [DW-1:0]           mem_rd
);

    localparam int IDX_W  = idx_w(NUM_PORTS);
    localparam int WAIT_W = wait_w(WAIT_CYCLES);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_PORTS - 1);

    arb_state_t          state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                we_q, we_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       rdata_q, rdata_d;

    logic [IDX_W-1:0]     ptr;
    logic [NUM_PORTS-1:0] gnt;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_hit;

    mem_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .gnt   (gnt),
        .idx   (win_idx),
        .hit   (win_hit)
    );

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_hit) ptr_d = win_idx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= PTR_RST;
        else          ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = PTR_RST;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (win_hit) begin
                    idx_d       = win_idx;
                    addr_d      = req_addr[int'(win_idx)*AW +: AW];
                    addr_d[1:0] = 2'b00;
                    we_d        = req_we[win_idx];
                    wdata_d     = req_wdata[int'(win_idx)*DW +: DW];
                    cnt_d       = WAIT_W'(WAIT_CYCLES);
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    // Sampled for writes too; the value is simply ignored upstream.
                    rdata_d = mem_rd;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory bus is quiet outside ACCESS; write strobe only on the final ACCESS cycle.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mem_addr  = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        if (state_q == IDLE) req_ready = gnt;
        if (state_q == ACCESS) begin
            mem_addr = addr_q;
            mem_wd   = wdata_q;
            mem_we   = we_q & (cnt_q == '0);
        end
        if (state_q == RESP) begin
            for (int i = 0; i < NUM_PORTS; i++) rsp_valid[i] = (idx_q == IDX_W'(i));
        end
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with one wait state, one with none.
module tb_mem_arbiter;

    localparam int NP = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [NP*32-1:0] req_addr, req_wdata;
    logic [31:0]      rsp_rdata, mem_addr, mem_wd, mem_rd;
    logic             mem_we;

    logic [NP-1:0]    b_valid, b_we, b_ready, b_rsp_valid;
    logic [NP*32-1:0] b_addr, b_wdata;
    logic [31:0]      b_rdata, b_mem_addr, b_mem_wd, b_mem_rd;
    logic             b_mem_we;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic        mem_load;

    mem_arbiter #(.NUM_PORTS(NP), .WAIT_CYCLES(1), .AW(32), .DW(32)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_arbiter #(.NUM_PORTS(NP), .WAIT_CYCLES(0), .AW(32), .DW(32)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
    );

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= 32'hA000_0000 + 32'(i);
                mem_b[i] <= 32'hB000_0000 + 32'(i);
            end
            mem_a[4]  <= 32'hDEAD_BEEF;
            mem_a[12] <= 32'h0C0C_0C0C;
        end else begin
            if (mem_we)   mem_a[mem_addr[7:2]]   <= mem_wd;
            if (b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wd;
        end
    end
    assign mem_rd   = mem_a[mem_addr[7:2]];
    assign b_mem_rd = mem_b[b_mem_addr[7:2]];

`ifdef MEM_ARB_RR_EN
    localparam int NG = 4;
    int          order [NG] = '{0, 1, 2, 0};
    logic [2:0]  vec   [NG] = '{3'b111, 3'b111, 3'b101, 3'b001};
`else
    localparam int NG = 3;
    int          order [NG] = '{0, 1, 2};
    logic [2:0]  vec   [NG] = '{3'b111, 3'b110, 3'b100};
`endif

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        req_valid[p]          = 1'b1;
        req_we[p]             = we;
        req_addr[p*32 +: 32]  = addr;
        req_wdata[p*32 +: 32] = wd;
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_load  = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        b_valid   = '0; b_we   = '0; b_addr   = '0; b_wdata   = '0;
        tick();
        tick();
        chk("rst_ready",  32'(req_ready), 32'h0);
        chk("rst_rsp",    32'(rsp_valid), 32'h0);
        chk("rst_we",     32'(mem_we),    32'h0);
        chk("rst_addr",   mem_addr,       32'h0);
        chk("rst_wd",     mem_wd,         32'h0);
        chk("rst_rdata",  rsp_rdata,      32'h0);
        mem_load = 1'b0;
        reset_n  = 1'b1;
        tick();

        // Single read, port 1
        drive(1, 1'b0, 32'h0000_0010, 32'h0);
        #1;
        chk("t1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("t1_addr_a",    mem_addr,       32'h10);
        chk("t1_ready_off", 32'(req_ready), 32'h0);
        tick();
        chk("t1_addr_b", mem_addr,       32'h10);
        chk("t1_no_we",  32'(mem_we),    32'h0);
        chk("t1_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        chk("t1_rsp",   32'(rsp_valid), 32'h2);
        chk("t1_rdata", rsp_rdata,      32'hDEAD_BEEF);
        tick();
        chk("t1_rsp_off", 32'(rsp_valid), 32'h0);
        chk("t1_hold",    rsp_rdata,      32'hDEAD_BEEF);

        // Write, port 0, unaligned byte address
        drive(0, 1'b1, 32'h0000_0022, 32'h1234_5678);
        #1;
        chk("t2_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0; req_we = '0;
        chk("t2_addr",   mem_addr,    32'h20);
        chk("t2_wd",     mem_wd,      32'h1234_5678);
        chk("t2_we_pre", 32'(mem_we), 32'h0);
        tick();
        chk("t2_we", 32'(mem_we), 32'h1);
        tick();
        chk("t2_we_post", 32'(mem_we),    32'h0);
        chk("t2_rsp",     32'(rsp_valid), 32'h1);
        tick();
        chk("t2_mem", mem_a[8], 32'h1234_5678);
        drive(0, 1'b0, 32'h0000_0020, 32'h0);
        #1;
        chk("t2_rd_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t2_rd_rsp",   32'(rsp_valid), 32'h1);
        chk("t2_rd_rdata", rsp_rdata,      32'h1234_5678);
        tick();

        // Simultaneous requests; each port reads word index == port
        for (int p = 0; p < NP; p++) drive(p, 1'b0, 32'(p * 4), 32'h0);
        for (int k = 0; k < NG; k++) begin
            req_valid = vec[k];
            #1;
            chk($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(1) << order[k]);
            tick();
            chk($sformatf("t3_busy%0d", k), 32'(req_ready), 32'h0);
            tick();
            tick();
            chk($sformatf("t3_rsp%0d", k),   32'(rsp_valid), 32'(1) << order[k]);
            chk($sformatf("t3_rdata%0d", k), rsp_rdata,      32'hA000_0000 + 32'(order[k]));
            chk($sformatf("t3_resp_rdy%0d", k), 32'(req_ready), 32'h0);
            tick();
        end
        req_valid = '0;
        tick();

        // Reset during the first ACCESS cycle of a write
        drive(0, 1'b1, 32'h0000_0030, 32'hAAAA_5555);
        #1;
        chk("t4_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t4_addr", mem_addr, 32'h30);
        reset_n   = 1'b0;
        req_valid = '0; req_we = '0;
        #1;
        chk("t4_addr0",  mem_addr,       32'h0);
        chk("t4_wd0",    mem_wd,         32'h0);
        chk("t4_rdata0", rsp_rdata,      32'h0);
        chk("t4_we0",    32'(mem_we),    32'h0);
        chk("t4_rsp0",   32'(rsp_valid), 32'h0);
        tick();
        chk("t4_we1",  32'(mem_we),    32'h0);
        chk("t4_rsp1", 32'(rsp_valid), 32'h0);
        tick();
        chk("t4_rsp2", 32'(rsp_valid), 32'h0);
        reset_n = 1'b1;
        chk("t4_mem", mem_a[12], 32'h0C0C_0C0C);
        tick();
        req_valid = 3'b111;
        #1;
        chk("t4_first", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t4_rd_rsp",   32'(rsp_valid), 32'h1);
        chk("t4_rd_rdata", rsp_rdata,      32'h0C0C_0C0C);
        tick();

        // Zero wait states, back-to-back reads from port 2
        b_valid        = 3'b100;
        b_addr[64 +: 32] = 32'h0000_0014;
        #1;
        chk("t5_ready_a", 32'(b_ready),     32'h4);
        chk("t5_idle_rsp", 32'(b_rsp_valid), 32'h0);
        tick();
        b_addr[64 +: 32] = 32'h0000_0018;
        chk("t5_addr_a", b_mem_addr,    32'h14);
        chk("t5_busy_a", 32'(b_ready),  32'h0);
        tick();
        chk("t5_rsp_a",   32'(b_rsp_valid), 32'h4);
        chk("t5_rdata_a", b_rdata,          32'hB000_0005);
        chk("t5_resp_rdy", 32'(b_ready),    32'h0);
        tick();
        chk("t5_ready_b", 32'(b_ready), 32'h4);
        tick();
        b_valid = '0;
        chk("t5_addr_b", b_mem_addr, 32'h18);
        tick();
        chk("t5_rsp_b",   32'(b_rsp_valid), 32'h4);
        chk("t5_rdata_b", b_rdata,          32'hB000_0006);
        tick();
        chk("t5_rsp_off", 32'(b_rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between NUM_PORTS requesters: instruction fetch, data load/store, and debug/loader.
- Sits between the multi-cycle control/datapath and the memory. Drives the memory's word-indexed address, its write enable and write data, and returns its combinational read data.
- Adds a configurable wait-state counter so slower memories can be modelled without changing the controller FSM.

Parameters:
- NUM_PORTS, 3, number of requesters; index 0 has the highest fixed priority.
- WAIT_CYCLES, 1, extra cycles the address is held before sampling or writing (0 is legal).
- AW, 32, byte address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- req_valid  in  NUM_PORTS  per-port request; held high until accepted.
- req_we  in  NUM_PORTS  per-port write flag (1 = store).
- req_addr  in  NUM_PORTS*AW  per-port byte address; bits [1:0] are ignored.
- req_wdata  in  NUM_PORTS*DW  per-port write data.
- req_ready  out  NUM_PORTS  one-hot accept pulse.
- rsp_valid  out  NUM_PORTS  one-hot completion pulse, for both reads and writes.
- rsp_rdata  out  DW  read data; valid when any rsp_valid bit is high.
- mem_addr  out  AW  address to memory.
- mem_we  out  1  memory write enable.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  combinational memory read data.

Behaviour:
- Reset is asynchronous and active-low. The clock port is clk and the reset port is reset_n.
- While reset_n=0: state=IDLE; req_ready, rsp_valid, mem_we = 0; mem_addr, mem_wd, rsp_rdata = 0; wait counter = 0; RR pointer = NUM_PORTS-1.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, pick a winner W by priority.
  - Assert req_ready[W] combinationally for this cycle only.
  - Latch addr/we/wdata of W and the index W.
  - Load counter=WAIT_CYCLES and go to ACCESS.
  - With no request, stay in IDLE with all outputs at 0.
- ACCESS:
  - mem_addr and mem_wd are driven from the latched values; mem_addr[1:0] is forced to 0.
  - If counter!=0: decrement and stay.
  - If counter==0 (final cycle): mem_we = latched we for exactly this one cycle, rsp_rdata register <= mem_rd (for writes too), then go to RESP.
- RESP:
  - rsp_valid[W]=1 for one cycle, rsp_rdata is held, mem_we=0.
  - Go to IDLE.
  - rsp_rdata holds its value until the next RESP.
- Latency: accept at cycle T; mem_we or read sample at T+1+WAIT_CYCLES; rsp_valid at T+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 cycles.
- req_valid is sampled only in IDLE. Requests arriving during ACCESS/RESP wait.
- Deasserting req_valid before req_ready is a protocol violation; the arbiter does not track it.
- Simultaneous requests: exactly one req_ready bit is set. Losers keep req_valid high and are re-arbitrated in the next IDLE.
- Reset mid-ACCESS: the access is aborted. No mem_we pulse and no rsp_valid is produced; FSM goes to IDLE.
- Addresses wrap naturally at 2^AW. No bounds checking is done.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin priority.
  - The search starts at (last_grant+1) mod NUM_PORTS.
  - The pointer updates on each req_ready.
  - Reset pointer is NUM_PORTS-1, so port 0 wins first after reset.
- Undefined: fixed priority, lowest index wins. No pointer register exists.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, ACCESS, RESP};
  - index width localparam IDX_W = $clog2(NUM_PORTS) helper function;
  - constant WAIT_W for the counter width.
- Sub-module mem_arb_pick: combinational winner select. Inputs are valid vector and pointer; outputs are one-hot grant and index. It contains the MEM_ARB_RR_EN branch.

Test Plan:
- Single read, port 1, addr 0x0000_0010, memory word[4]=0xDEAD_BEEF, WAIT_CYCLES=1 -> req_ready[1] at T, mem_addr=0x10 at T+1..T+2, rsp_valid[1]=1 with rsp_rdata=0xDEAD_BEEF at T+3.
- Write, port 0, addr 0x0000_0022, wdata 0x1234_5678 -> mem_addr=0x20, mem_we high for exactly 1 cycle, rsp_valid[0] next cycle; a later read of 0x20 returns 0x1234_5678.
- Ports 0, 1 and 2 requesting together, fixed priority -> grants in order 0, 1, 2, each WAIT_CYCLES+3 cycles apart.
- Same stimulus with MEM_ARB_RR_EN: port 0 granted, then port 0 re-requests -> order 0, 1, 2, 0.
- reset_n pulsed low during the first ACCESS cycle of a write -> no mem_we, no rsp_valid, all outputs 0 immediately; memory unchanged.
- WAIT_CYCLES=0, back-to-back reads from port 2 -> rsp_valid 2 cycles after each accept, accepts 3 cycles apart.
